output_port_arbiter: RTL and testbench
======================================

# output_port_arbiter

Per-output-port arbiter and output register of the router, sitting directly downstream of the four input ports' 1x4 flit demultiplexers. Each input port delivers a routed (modified) flit toward this output; the block selects one input by round-robin, locks onto it for the whole packet (wormhole), and drives the flit to the link through a single output register that honours downstream back-pressure (`portBlock`). One instance per router output port.

## Interface
- `modifiedFlitSize`, 34: width of a routed flit; bits [modifiedFlitSize-1:modifiedFlitSize-2] are the flit type.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset_n`  in  1  synchronous, active-low reset, sampled on the rising edge of `clk`.
- `inFlit1`..`inFlit4`  in  modifiedFlitSize each  flit from input port 1..4 demux (port 1 = local/self).
- `inValid1`..`inValid4`  in  1 each  corresponding `inFlitN` is valid.
- `inReady1`..`inReady4`  out  1 each  flit on port N is consumed this cycle (combinational).
- `portBlock`  in  1  high = downstream cannot take a flit this cycle.
- `outFlit`  out  modifiedFlitSize  registered output flit.
- `outValid`  out  1  `outFlit` holds a flit not yet taken downstream.
- `protocolError`  out  1  sticky; set on a protocol violation, cleared only by reset.

## Operation
- Flit type field: 2'b01 head, 2'b10 body, 2'b11 tail, 2'b00 single (head and tail in one flit).
- Transfer on port N: `inValidN && inReadyN` in the same cycle.
- Output register may load when `loadEn = !outValid || !portBlock`. The downstream takes the flit on any cycle with `outValid && !portBlock`.
- States:
  - IDLE: candidates are ports with `inValidN` and type head or single. Search starts at round-robin pointer `rrPtr` (0..3 = port 1..4) and wraps mod 4; the first candidate wins. If there is a winner and `loadEn`, assert that port's `inReady`, load its flit, and latch `grant` = winner.
    - Head winner -> LOCKED.
    - Single winner -> stay IDLE, `rrPtr` <= winner+1 mod 4.
  - LOCKED: only `inReady[grant]` may assert, equal to `inValid[grant] && loadEn`. Head or single from the granted port is not accepted and sets `protocolError`. Body and tail are accepted. An accepted tail -> IDLE, `rrPtr` <= grant+1 mod 4.
- Body or tail flits presented on a port in IDLE are never granted and set `protocolError`. Other ports stay stalled while locked.
- Only one `inReadyN` may be high in any cycle.
- When `outValid && portBlock`, `outFlit` and `outValid` hold stable and all `inReady` are 0.
- When `loadEn` is true and nothing is accepted, `outValid` <= 0.
- Reset mid-packet: lock dropped, state -> IDLE, partial packet lost. Upstream is reset on the same `reset_n`.

## Timing
- Reset values: `outValid`=0, `outFlit`=0, `protocolError`=0, state IDLE, `rrPtr`=0, `grant`=0. `inReadyN`=0 while `reset_n`=0.
- Latency: a flit accepted in cycle T appears on `outFlit`/`outValid` in cycle T+1.
- Throughput: 1 flit/cycle with `portBlock` low. The head of the next packet (any port) can be accepted in the cycle after the previous tail, so packets have no bubble between them.
- `inReadyN` depends combinationally on `inValidN`, the type field, state, `rrPtr`, `outValid` and `portBlock`. There is no combinational path from `inFlitN` data bits to `outFlit`.
- `portBlock` raised while `outValid`=1: the flit stays valid until the first cycle with `portBlock` low, then it is taken and replaced in the same edge if a flit is accepted.

## Test plan
- Reset then idle: hold `reset_n`=0 for 2 cycles -> all outputs 0. Release with no valids -> `outValid` stays 0.
- Single-flit packet on port 3 (type 00, payload 0x1234): `inReady3`=1 in cycle T; `outFlit`=that flit and `outValid`=1 at T+1; `rrPtr`=3 (port 4) afterwards.
- Wormhole lock: port 2 sends head/body/body/tail while port 1 holds a valid head throughout.
  - Port 2 flits appear on 4 consecutive cycles and `inReady1` stays 0.
  - Port 1 head is accepted the cycle after the port-2 tail.
- Round-robin fairness: all four ports continuously offer single flits -> grant order 1,2,3,4,1,… with one flit per cycle.
- Back-pressure: `portBlock`=1 for 3 cycles mid-packet -> `outFlit` stable, all `inReady`=0, no flit lost or duplicated; the stream resumes in order when `portBlock` falls.
- Protocol error and reset mid-packet: body flit on port 4 while IDLE -> `protocolError`=1 and sticky, flit not accepted. Assert `reset_n`=0 mid-packet -> state IDLE, `outValid`=0, `protocolError`=0 after reset.

Source files
------------

// File: rtl/output_port_arbiter.sv
`default_nettype none
// ============================================================================
// output_port_arbiter : round-robin wormhole arbiter and output flit register
// Rev 1.0
// ============================================================================
module output_port_arbiter #(
  parameter int MODIFIED_FLIT_SIZE = 34
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [MODIFIED_FLIT_SIZE-1:0] inFlit1,
  input  logic [MODIFIED_FLIT_SIZE-1:0] inFlit2,
  input  logic [MODIFIED_FLIT_SIZE-1:0] inFlit3,
  input  logic [MODIFIED_FLIT_SIZE-1:0] inFlit4,
  input  logic                          inValid1,
  input  logic                          inValid2,
  input  logic                          inValid3,
  input  logic                          inValid4,
  output logic                          inReady1,
  output logic                          inReady2,
  output logic                          inReady3,
  output logic                          inReady4,
  input  logic                          portBlock,
  output logic [MODIFIED_FLIT_SIZE-1:0] outFlit,
  output logic                          outValid,
  output logic                          protocolError
);

  localparam int         c_W        = MODIFIED_FLIT_SIZE;
  localparam logic [1:0] c_TYPE_HEAD = 2'b01;
  localparam logic [1:0] c_TYPE_TAIL = 2'b11;

  typedef enum logic [0:0] {
    S_IDLE   = 1'b0,
    S_LOCKED = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_stateNext;
  logic [1:0]       r_rrPtr;
  logic [1:0]       w_rrPtrNext;
  logic [1:0]       r_grant;
  logic [1:0]       w_grantNext;
  logic [c_W-1:0]   r_outFlit;
  logic             r_outValid;
  logic             r_protocolError;

  logic [c_W-1:0]   w_flit [4];
  logic [3:0]       w_valid;
  logic [3:0]       w_isStart;
  logic [3:0]       w_isCont;
  logic [3:0]       w_ready;
  logic [1:0]       w_win;
  logic [1:0]       w_sel;
  logic             w_winFound;
  logic             w_loadEn;
  logic             w_accept;
  logic             w_protoViol;

  assign w_flit[0] = inFlit1;
  assign w_flit[1] = inFlit2;
  assign w_flit[2] = inFlit3;
  assign w_flit[3] = inFlit4;
  assign w_valid   = {inValid4, inValid3, inValid2, inValid1};

  assign w_loadEn  = !r_outValid || !portBlock;
  assign w_accept  = |w_ready;

  // Type bit 1 separates packet starters (head/single) from continuations (body/tail).
  always_comb begin
    w_isStart = '0;
    w_isCont  = '0;
    for (int i = 0; i < 4; i++) begin
      w_isStart[i] = w_valid[i] && !w_flit[i][c_W-1];
      w_isCont[i]  = w_valid[i] &&  w_flit[i][c_W-1];
    end
  end

  // Scan from the highest offset down so the candidate closest to r_rrPtr wins.
  always_comb begin
    w_winFound = 1'b0;
    w_win      = r_rrPtr;
    for (int k = 3; k >= 0; k--) begin
      if (w_isStart[r_rrPtr + 2'(k)]) begin
        w_winFound = 1'b1;
        w_win      = r_rrPtr + 2'(k);
      end
    end
  end

  always_comb begin
    w_stateNext = r_state;
    w_rrPtrNext = r_rrPtr;
    w_grantNext = r_grant;
    w_ready     = '0;
    w_sel       = r_grant;
    w_protoViol = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_protoViol = |w_isCont;
        w_sel       = w_win;
        if (w_winFound && w_loadEn) begin
          w_ready[w_win] = 1'b1;
          w_grantNext    = w_win;
          if (w_flit[w_win][c_W-1:c_W-2] == c_TYPE_HEAD) begin
            w_stateNext = S_LOCKED;
          end else begin
            w_rrPtrNext = w_win + 2'd1;
          end
        end
      end
      S_LOCKED: begin
        w_protoViol = w_isStart[r_grant];
        if (w_isCont[r_grant] && w_loadEn) begin
          w_ready[r_grant] = 1'b1;
          if (w_flit[r_grant][c_W-1:c_W-2] == c_TYPE_TAIL) begin
            w_stateNext = S_IDLE;
            w_rrPtrNext = r_grant + 2'd1;
          end
        end
      end
      default: w_stateNext = S_IDLE;
    endcase
    if (!reset_n) begin
      w_ready = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_rrPtr <= 2'd0;
      r_grant <= 2'd0;
    end else begin
      r_state <= w_stateNext;
      r_rrPtr <= w_rrPtrNext;
      r_grant <= w_grantNext;
    end
  end

  // outFlit keeps its last value when the register empties without a new load.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_outFlit       <= '0;
      r_outValid      <= 1'b0;
      r_protocolError <= 1'b0;
    end else begin
      if (w_protoViol) begin
        r_protocolError <= 1'b1;
      end
      if (w_loadEn) begin
        r_outValid <= w_accept;
        if (w_accept) begin
          r_outFlit <= w_flit[w_sel];
        end
      end
    end
  end

  assign inReady1      = w_ready[0];
  assign inReady2      = w_ready[1];
  assign inReady3      = w_ready[2];
  assign inReady4      = w_ready[3];
  assign outFlit       = r_outFlit;
  assign outValid      = r_outValid;
  assign protocolError = r_protocolError;

endmodule
`default_nettype wire

// File: tb/tb_output_port_arbiter.sv
`default_nettype none
// tb_output_port_arbiter : directed steps plus randomized traffic against a
// packet-level reference model and an in-order receiver scoreboard.
module tb_output_port_arbiter;

  localparam int W = 34;
  typedef logic [W-1:0] flit_t;
  localparam logic [1:0] T_SINGLE = 2'b00;
  localparam logic [1:0] T_HEAD   = 2'b01;
  localparam logic [1:0] T_BODY   = 2'b10;
  localparam logic [1:0] T_TAIL   = 2'b11;

  logic  clk = 1'b0;
  logic  reset_n = 1'b0;
  logic  portBlock = 1'b0;
  flit_t tb_flit [4];
  logic  tb_valid [4];
  logic  inReady1, inReady2, inReady3, inReady4;
  flit_t outFlit;
  logic  outValid, protocolError;

  int checks = 0;
  int errors = 0;

  // reference model of the arbiter's observable state
  bit    m_locked;
  int    m_grant, m_rr;
  bit    m_outValid, m_err;
  flit_t m_outFlit;

  // upstream sources, receiver and logs
  flit_t srcq [4][$];
  bit    present [4];
  bit    dir_mode = 1'b1;
  int    tx_seq [4];
  int    pkt_id = 0;
  int    obslog [$];
  bit    rx_check = 1'b0;
  int    rx_seq [4];
  int    rx_pkt = -1;
  int    rx_taken = 0;
  int    tx_accepted = 0;

  always #5 clk = ~clk;

  output_port_arbiter #(.MODIFIED_FLIT_SIZE(W)) dut (
    .clk(clk), .reset_n(reset_n),
    .inFlit1(tb_flit[0]), .inFlit2(tb_flit[1]), .inFlit3(tb_flit[2]), .inFlit4(tb_flit[3]),
    .inValid1(tb_valid[0]), .inValid2(tb_valid[1]), .inValid3(tb_valid[2]), .inValid4(tb_valid[3]),
    .inReady1(inReady1), .inReady2(inReady2), .inReady3(inReady3), .inReady4(inReady4),
    .portBlock(portBlock), .outFlit(outFlit), .outValid(outValid), .protocolError(protocolError)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_locked = 0; m_grant = 0; m_rr = 0;
    m_outValid = 0; m_err = 0; m_outFlit = '0;
  endtask

  task automatic gen_packet(input int p, input int len);
    logic [1:0] ty;
    for (int i = 0; i < len; i++) begin
      if (len == 1)         ty = T_SINGLE;
      else if (i == 0)      ty = T_HEAD;
      else if (i == len-1)  ty = T_TAIL;
      else                  ty = T_BODY;
      srcq[p].push_back({ty, 2'(p), 14'(pkt_id), 16'(tx_seq[p])});
      tx_seq[p]++;
    end
    pkt_id++;
  endtask

  task automatic drive_sources();
    for (int p = 0; p < 4; p++) begin
      if (srcq[p].size() > 0 && (present[p] || dir_mode || $urandom_range(3) != 0)) begin
        present[p]  = 1'b1;
        tb_valid[p] = 1'b1;
        tb_flit[p]  = srcq[p][0];
      end else begin
        tb_valid[p] = 1'b0;
        tb_flit[p]  = 34'({$urandom(), $urandom()});
      end
    end
  endtask

  task automatic receive(input flit_t f);
    int pp;
    pp = int'(f[31:30]);
    check("rx_seq", f[15:0], 16'(rx_seq[pp]));
    rx_seq[pp]++;
    if (rx_pkt >= 0) check("rx_wormhole", pp, rx_pkt);
    else             check("rx_pkt_start", f[33], 1'b0);
    if (f[33:32] == T_HEAD)      rx_pkt = pp;
    else if (f[33:32] == T_TAIL) rx_pkt = -1;
  endtask

  // One clock: present sources, check DUT against model at negedge, advance model.
  task automatic cycle();
    bit loadEn, viol;
    int win, acc, obs_port;
    logic [3:0] exp_rdy, obs_rdy;
    logic [1:0] ty;
    drive_sources();
    @(negedge clk);
    loadEn = !m_outValid || !portBlock;
    win = -1; acc = -1; viol = 0;
    if (!m_locked) begin
      for (int k = 0; k < 4; k++) begin
        if (win < 0 && tb_valid[(m_rr+k)%4] && tb_flit[(m_rr+k)%4][33] == 1'b0)
          win = (m_rr + k) % 4;
      end
      for (int p = 0; p < 4; p++)
        if (tb_valid[p] && tb_flit[p][33]) viol = 1;
      if (win >= 0 && loadEn) acc = win;
    end else begin
      if (tb_valid[m_grant] && tb_flit[m_grant][33] && loadEn) acc = m_grant;
      if (tb_valid[m_grant] && !tb_flit[m_grant][33]) viol = 1;
    end
    if (!reset_n) begin
      acc = -1; viol = 0;
    end
    exp_rdy = (acc >= 0) ? 4'(1 << acc) : 4'b0000;
    obs_rdy = {inReady4, inReady3, inReady2, inReady1};
    check("inReady", obs_rdy, exp_rdy);
    check("outValid", outValid, m_outValid);
    if (m_outValid) check("outFlit", outFlit, m_outFlit);
    check("protocolError", protocolError, m_err);
    case (obs_rdy)
      4'b0000: obs_port = -1;
      4'b0001: obs_port = 0;
      4'b0010: obs_port = 1;
      4'b0100: obs_port = 2;
      4'b1000: obs_port = 3;
      default: obs_port = -2;
    endcase
    obslog.push_back(obs_port);
    if (reset_n && m_outValid && !portBlock) begin
      rx_taken++;
      if (rx_check) receive(outFlit);
    end
    @(posedge clk);
    #1;
    if (!reset_n) begin
      model_reset();
    end else begin
      if (viol) m_err = 1;
      if (loadEn) begin
        m_outValid = (acc >= 0);
        if (acc >= 0) m_outFlit = tb_flit[acc];
      end
      if (acc >= 0) begin
        ty = tb_flit[acc][33:32];
        tx_accepted++;
        void'(srcq[acc].pop_front());
        present[acc] = 1'b0;
        if (!m_locked) begin
          m_grant = acc;
          if (ty == T_HEAD) m_locked = 1;
          else              m_rr = (acc + 1) % 4;
        end else if (ty == T_TAIL) begin
          m_locked = 0;
          m_rr = (m_grant + 1) % 4;
        end
      end
    end
  endtask

  function automatic int pending();
    return srcq[0].size() + srcq[1].size() + srcq[2].size() + srcq[3].size();
  endfunction

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (pending() != 0 && n < 200) begin
      cycle();
      n++;
    end
    check({tag, "_drained"}, pending(), 0);
  endtask

  task automatic clear_sources();
    for (int p = 0; p < 4; p++) begin
      srcq[p].delete();
      present[p] = 1'b0;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int rx_base, tx_base;
    flit_t saved;
    model_reset();
    for (int p = 0; p < 4; p++) begin
      tb_valid[p] = 1'b0; tb_flit[p] = '0; present[p] = 1'b0; tx_seq[p] = 0; rx_seq[p] = 0;
    end

    // reset for two cycles, then idle
    reset_n = 1'b0;
    cycle(); cycle();
    check("rst_outFlit", outFlit, '0);
    check("rst_outValid", outValid, 1'b0);
    reset_n = 1'b1;
    cycle(); cycle();
    check("idle_outValid", outValid, 1'b0);

    // single flit on port 3
    srcq[2].push_back({T_SINGLE, 32'h0000_1234});
    cycle();
    check("single_p3_ready", obslog[$], 2);
    check("single_p3_out", {outValid, outFlit}, {1'b1, 34'h0_0000_1234});
    // pointer now at port 4
    for (int p = 0; p < 4; p++) gen_packet(p, 1);
    cycle();
    check("rr_after_single", obslog[$], 3);
    drain("rr1");

    // round-robin fairness starting from port 1
    gen_packet(3, 1);
    drain("rr_prep");
    for (int p = 0; p < 4; p++) begin gen_packet(p, 1); gen_packet(p, 1); end
    base = obslog.size();
    repeat (8) cycle();
    for (int i = 0; i < 8; i++) check("rr_order", obslog[base+i], i % 4);

    // wormhole: port 2 packet, port 1 head waits
    gen_packet(1, 4);
    cycle();
    check("worm_head_p2", obslog[$], 1);
    gen_packet(0, 2);
    base = obslog.size();
    repeat (6) cycle();
    for (int i = 0; i < 3; i++) check("worm_p2_cont", obslog[base+i], 1);
    check("worm_p1_head", obslog[base+3], 0);
    check("worm_p1_tail", obslog[base+4], 0);

    // back-pressure mid-packet
    gen_packet(2, 5);
    cycle(); cycle();
    portBlock = 1'b1;
    saved = outFlit;
    repeat (3) begin
      cycle();
      check("bp_ready", obslog[$], -1);
      check("bp_hold", {outValid, outFlit}, {1'b1, saved});
    end
    portBlock = 1'b0;
    drain("bp");
    cycle();

    // protocol error: body on port 4 while idle
    srcq[3].push_back({T_BODY, 32'h0000_0BAD});
    cycle();
    check("perr_not_acc", obslog[$], -1);
    check("perr_set", protocolError, 1'b1);
    clear_sources();
    cycle(); cycle();
    check("perr_sticky", protocolError, 1'b1);

    // reset mid-packet
    gen_packet(0, 4);
    cycle(); cycle();
    reset_n = 1'b0;
    clear_sources();
    cycle(); cycle();
    reset_n = 1'b1;
    check("rst_mid_outValid", outValid, 1'b0);
    check("rst_mid_perr", protocolError, 1'b0);
    gen_packet(1, 1);
    cycle();
    check("rst_lock_dropped", obslog[$], 1);
    cycle();

    // randomized traffic with back-pressure
    for (int p = 0; p < 4; p++) rx_seq[p] = tx_seq[p];
    rx_pkt = -1;
    rx_check = 1'b1;
    rx_base = rx_taken;
    tx_base = tx_accepted;
    dir_mode = 1'b0;
    repeat (3000) begin
      for (int p = 0; p < 4; p++)
        if (srcq[p].size() == 0 && $urandom_range(9) == 0) gen_packet(p, $urandom_range(5, 1));
      portBlock = ($urandom_range(9) < 3);
      cycle();
    end
    portBlock = 1'b0;
    dir_mode = 1'b1;
    drain("rand");
    cycle(); cycle();
    check("rand_no_loss", rx_taken - rx_base, tx_accepted - tx_base);
    check("rand_final_perr", protocolError, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
